mtimer: RTL and testbench
=========================

# mtimer

Memory-mapped machine timer on the core's OBI data port, behind the address decode in `bus`. It holds a 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp`. It drives a level machine-timer interrupt into core `irq[7]`. It answers data requests with the same `req`/`gnt`/`rvalid` handshake that `bus` expects from its slaves.

## Interface
- `BASE_ADDR`, default 32'h0000_2000: byte address of register 0; window is 32 bytes, aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: data request from bus.
- `we` in 1: 1 = write, 0 = read.
- `be` in 4: byte enables for writes.
- `addr` in 32: byte address; only `addr[4:2]` decoded, window match already done by bus.
- `wdata` in 32: write data.
- `gnt` out 1: request accepted.
- `rvalid` out 1: response valid, one per accepted request.
- `rdata` out 32: read data, qualified by `rvalid`.
- `irq` out 1: timer interrupt, level.

## Operation
- Register map (offset): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 STATUS; 0x18/0x1C reserved.
- CTRL fields: [0] EN; [15:8] PRESC. Other bits read 0, writes ignored.
- STATUS fields: [0] PENDING, which equals `irq`. STATUS is read-only.
- Reserved offsets read 0, and writes to them are ignored. They are still granted and answered.
- Byte enables apply to every writable register. A byte with `be` clear keeps its old value.
- Prescaler:
  - 8-bit counter `pcnt` runs while EN=1.
  - When `pcnt == PRESC`: `pcnt` returns to 0 and `mtime` increments by 1.
  - PRESC=0 increments `mtime` every cycle.
  - EN=0 freezes both `pcnt` and `mtime`.
- `mtime` is 64-bit, wraps 2^64−1 → 0. The carry from LO to HI is internal; there is no torn increment.
- Coherent read:
  - Reading MTIME_LO copies the current `mtime[63:32]` into a 32-bit shadow.
  - Reading MTIME_HI returns the shadow, not live `mtime[63:32]`.
  - Shadow resets to 0.
- Simultaneous write and increment: a bus write to MTIME_LO or MTIME_HI in the same cycle as a tick wins.
  - The written half takes `wdata`.
  - The other half keeps its value.
  - No increment that cycle.
- Writing CTRL clears `pcnt` to 0.
- Interrupt: `irq` is registered and equals `EN & (mtime >= mtimecmp)` (unsigned 64-bit), evaluated on the state before the edge. It clears only when the compare becomes false or EN=0.
- Reset values:
  - `mtime` = 0, shadow = 0, `pcnt` = 0.
  - `mtimecmp` = all ones.
  - CTRL = 0.
  - `irq`, `rvalid` = 0; `rdata` = 0.

## Timing
- `gnt = req`, combinational; every request is accepted in its cycle.
- A request accepted at edge N gets `rvalid` = 1 for exactly one cycle, after edge N (cycle N+1). This applies to writes too; they carry `rdata` = 0.
- Read data is the register value before any update at edge N.
- A write takes effect at edge N.
- Back-to-back requests every cycle are supported, giving continuous `rvalid`.
- `rdata` = 0 whenever `rvalid` = 0.
- `irq` latency:
  - Asserts 1 cycle after the tick that makes `mtime >= mtimecmp`.
  - Deasserts 1 cycle after the MTIMECMP write that makes the compare false.
- `rst` asserted mid-transaction: the pending response is dropped (`rvalid` = 0 next cycle) and all state returns to reset values. A request presented during reset is not answered.

## Structure
- Package `mtimer_pkg`:
  - Register offset constants (`MTIMER_MTIME_LO` … `MTIMER_STATUS`).
  - CTRL field positions and widths.
  - Reset value of `mtimecmp`.
- One sub-module: `mtimer_presc`, the 8-bit prescaler. Inputs: `en`, `presc`, `clr`. Output: one-cycle `tick`.
- Top holds the register file, the read mux, the response register and the compare.

## Test plan
- **Reset defaults:** after reset, read each of 0x00–0x14. Expect 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0; `irq` = 0; each `rvalid` exactly 1 cycle after its `req`.
- **Prescaled count:** write CTRL = 0x0000_0301 (PRESC=3, EN), idle 40 cycles, read MTIME_LO. Expect 10 ± 1.
- **Carry coherency:**
  - Set MTIME_LO = FFFF_FFFE and MTIME_HI = 0, with EN and PRESC=0.
  - Read LO then HI back-to-back, repeated over the wrap.
  - Each HI value matches the LO snapshot: HI=0 with LO≥FFFF_FFFE, or HI=1 with small LO.
- **Interrupt:**
  - Write MTIMECMP_HI = 0 and MTIMECMP_LO = 20, with EN and PRESC=0.
  - `irq` rises 1 cycle after `mtime` reaches 20; STATUS reads 1.
  - Write MTIMECMP_LO = FFFF_FFFF; `irq` falls 1 cycle later.
- **Write/tick collision and byte enables:**
  - Write MTIME_LO with `be`=4'b0001 and `wdata`=0xAA during a tick.
  - LO byte0 = 0xAA, upper bytes unchanged, no increment that cycle.
- **Reset mid-response:** issue a read, then assert `rst` on the next edge. Expect `rvalid` = 0, all registers back at reset values, no stray response after reset is released.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared constants and helpers for the machine timer.
package mtimer_pkg;

  // Register byte offsets within the 32-byte window
  localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_CTRL        = 5'h10;
  localparam logic [4:0] MTIMER_STATUS      = 5'h14;

  // CTRL field layout
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_PRESC_LSB = 8;
  localparam int unsigned CTRL_PRESC_W   = 8;

  localparam logic [63:0] MTIMECMP_RST = '1;

  // Merge new data into an old word, byte lane by byte lane
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// Data-port request/response bundle between bus and timer.
interface mtimer_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mtimer_presc.sv
// 8-bit prescaler: emits a one-cycle tick every PRESC+1 enabled cycles.
module mtimer_presc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] presc_i,
  input  logic       clr_i,
  output logic       tick_o
);
  logic [7:0] pcnt_q, pcnt_d;

  assign tick_o = en_i & (pcnt_q == presc_i);

  // Next count: clear wins, freeze when disabled, wrap on terminal count
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i)       pcnt_d = '0;
    else if (tick_o) pcnt_d = '0;
    else if (en_i)   pcnt_d = pcnt_q + 8'd1;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaler, level irq.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic   clk_i,
  input  logic   rst_i,
  mtimer_if.slave bus,
  output logic   irq_o
);
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        en_q, en_d;
  logic [7:0]  presc_q, presc_d;
  logic        irq_q, irq_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  off;
  logic        wr, rd, tick;

  // Window match happens upstream; only the word index is decoded here
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], BASE_ADDR};

  assign off = {bus.addr[4:2], 2'b00};
  assign wr  = bus.req & bus.we;
  assign rd  = bus.req & ~bus.we;

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign irq_o      = irq_q;

  mtimer_presc u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_q),
    .presc_i(presc_q),
    .clr_i  (wr && off == MTIMER_CTRL),
    .tick_o (tick)
  );

  // Register-file next state; a bus write to either mtime half overrides the tick
  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    presc_d  = presc_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr) begin
      unique case (off)
        MTIMER_MTIME_LO:    mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], bus.wdata, bus.be)};
        MTIMER_MTIME_HI:    mtime_d = {apply_be(mtime_q[63:32], bus.wdata, bus.be), mtime_q[31:0]};
        MTIMER_MTIMECMP_LO: cmp_d[31:0]  = apply_be(cmp_q[31:0], bus.wdata, bus.be);
        MTIMER_MTIMECMP_HI: cmp_d[63:32] = apply_be(cmp_q[63:32], bus.wdata, bus.be);
        MTIMER_CTRL: begin
          if (bus.be[0]) en_d    = bus.wdata[CTRL_EN_BIT];
          if (bus.be[1]) presc_d = bus.wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
        end
        default: ;
      endcase
    end
    if (rd && off == MTIMER_MTIME_LO) shadow_d = mtime_q[63:32];
    irq_d = en_q & (mtime_q >= cmp_q);
  end

  // Read mux on pre-edge state; writes answer with zero data
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (off)
        MTIMER_MTIME_LO:    rdata_d = mtime_q[31:0];
        MTIMER_MTIME_HI:    rdata_d = shadow_q;
        MTIMER_MTIMECMP_LO: rdata_d = cmp_q[31:0];
        MTIMER_MTIMECMP_HI: rdata_d = cmp_q[63:32];
        MTIMER_CTRL:        rdata_d = {16'h0, presc_q, 7'h0, en_q};
        MTIMER_STATUS:      rdata_d = {31'h0, irq_q};
        default:            rdata_d = '0;
      endcase
    end
  end

  // State and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q  <= '0;
      cmp_q    <= MTIMECMP_RST;
      shadow_q <= '0;
      en_q     <= 1'b0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
      rvalid_q <= bus.req;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer.
module tb_mtimer;
  import mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  mtimer_if bus_if ();

  mtimer #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single write; rvalid sampled in the cycle after the accepting edge
  task automatic bus_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be);
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = BASE + {27'h0, off};
    bus_if.wdata = d;
    bus_if.be    = be;
    @(posedge clk);
    #1 bus_if.req = 1'b0;
    bus_if.we = 1'b0;
    @(negedge clk);
    check("wr_rvalid", {63'h0, bus_if.rvalid}, 64'd1);
    check("wr_rdata", {32'h0, bus_if.rdata}, 64'd0);
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = BASE + {27'h0, off};
    #1 check("gnt", {63'h0, bus_if.gnt}, 64'd1);
    @(posedge clk);
    #1 bus_if.req = 1'b0;
    @(negedge clk);
    check("rd_rvalid", {63'h0, bus_if.rvalid}, 64'd1);
    d = bus_if.rdata;
  endtask

  // Back-to-back LO then HI read
  task automatic read_pair(output logic [31:0] lo, output logic [31:0] hi);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = BASE + {27'h0, MTIMER_MTIME_LO};
    @(posedge clk);
    #1 bus_if.addr = BASE + {27'h0, MTIMER_MTIME_HI};
    @(negedge clk);
    check("pair_rvalid_lo", {63'h0, bus_if.rvalid}, 64'd1);
    lo = bus_if.rdata;
    @(posedge clk);
    #1 bus_if.req = 1'b0;
    @(negedge clk);
    check("pair_rvalid_hi", {63'h0, bus_if.rvalid}, 64'd1);
    hi = bus_if.rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, lo, hi;
    logic [4:0]  offs [6];
    logic [31:0] exps [6];
    offs = '{MTIMER_MTIME_LO, MTIMER_MTIME_HI, MTIMER_MTIMECMP_LO,
             MTIMER_MTIMECMP_HI, MTIMER_CTRL, MTIMER_STATUS};
    exps = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.be = '0;
    bus_if.addr = '0; bus_if.wdata = '0;

    // Reset defaults, one-cycle rvalid
    do_reset();
    @(negedge clk);
    check("rst_rvalid", {63'h0, bus_if.rvalid}, 64'd0);
    check("rst_irq", {63'h0, irq}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      bus_read(offs[i], d);
      check("rst_reg", {32'h0, d}, {32'h0, exps[i]});
      @(negedge clk);
      check("rvalid_drop", {63'h0, bus_if.rvalid}, 64'd0);
      check("rdata_idle", {32'h0, bus_if.rdata}, 64'd0);
    end

    // Prescaled count: PRESC=3 gives a tick every 4 cycles
    do_reset();
    bus_write(MTIMER_CTRL, 32'h0000_0301, 4'hF);
    repeat (40) @(posedge clk);
    #1 bus_read(MTIMER_MTIME_LO, d);
    check("presc_count", {32'h0, d}, 64'd10);
    bus_read(MTIMER_CTRL, d);
    check("ctrl_rb", {32'h0, d}, 64'h301);

    // Carry coherency across the LO wrap
    do_reset();
    bus_write(MTIMER_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    bus_write(MTIMER_MTIME_HI, 32'h0, 4'hF);
    bus_write(MTIMER_CTRL, 32'h0000_0001, 4'hF);
    @(posedge clk);
    #1 read_pair(lo, hi);
    check("pair1_lo", {32'h0, lo}, 64'hFFFF_FFFF);
    check("pair1_hi", {32'h0, hi}, 64'd0);
    read_pair(lo, hi);
    check("pair2_lo", {32'h0, lo}, 64'd1);
    check("pair2_hi", {32'h0, hi}, 64'd1);
    read_pair(lo, hi);
    check("pair3_lo", {32'h0, lo}, 64'd3);
    check("pair3_hi", {32'h0, hi}, 64'd1);

    // Interrupt rise and fall
    do_reset();
    bus_write(MTIMER_MTIMECMP_HI, 32'h0, 4'hF);
    bus_write(MTIMER_MTIMECMP_LO, 32'd20, 4'hF);
    bus_write(MTIMER_CTRL, 32'h0000_0001, 4'hF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("irq_before", {63'h0, irq}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("irq_rise", {63'h0, irq}, 64'd1);
    bus_read(MTIMER_STATUS, d);
    check("status_pend", {32'h0, d}, 64'd1);
    bus_write(MTIMER_MTIMECMP_LO, 32'hFFFF_FFFF, 4'hF);
    check("irq_hold", {63'h0, irq}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("irq_fall", {63'h0, irq}, 64'd0);

    // Write/tick collision with a partial byte enable
    do_reset();
    bus_write(MTIMER_MTIME_LO, 32'h1122_3344, 4'hF);
    bus_write(MTIMER_CTRL, 32'h0000_0001, 4'hF);
    bus_write(MTIMER_MTIME_LO, 32'h0000_00AA, 4'b0001);
    bus_read(MTIMER_MTIME_LO, d);
    check("collide_lo", {32'h0, d}, 64'h1122_33AA);

    // Byte enables on compare, CTRL masking, reserved and read-only offsets
    do_reset();
    bus_write(MTIMER_MTIMECMP_HI, 32'h0000_5500, 4'b0010);
    bus_read(MTIMER_MTIMECMP_HI, d);
    check("cmp_be", {32'h0, d}, 64'hFFFF_55FF);
    bus_write(MTIMER_CTRL, 32'hFFFF_FF00, 4'hF);
    bus_read(MTIMER_CTRL, d);
    check("ctrl_mask", {32'h0, d}, 64'h0000_FF00);
    bus_write(5'h18, 32'hDEAD_BEEF, 4'hF);
    bus_read(5'h18, d);
    check("reserved", {32'h0, d}, 64'd0);
    bus_write(MTIMER_STATUS, 32'h1, 4'hF);
    bus_read(MTIMER_STATUS, d);
    check("status_ro", {32'h0, d}, 64'd0);

    // Reset mid-response drops the response and restores state
    do_reset();
    bus_write(MTIMER_MTIMECMP_LO, 32'h0000_1234, 4'hF);
    bus_write(MTIMER_CTRL, 32'h0000_0501, 4'hF);
    repeat (8) @(posedge clk);
    #1 bus_if.req = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = BASE + {27'h0, MTIMER_MTIMECMP_LO};
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rvalid", {63'h0, bus_if.rvalid}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus_if.req = 1'b0;
    @(negedge clk);
    check("rst_req_drop", {63'h0, bus_if.rvalid}, 64'd0);
    @(negedge clk);
    check("no_stray", {63'h0, bus_if.rvalid}, 64'd0);
    bus_read(MTIMER_CTRL, d);
    check("rst_ctrl", {32'h0, d}, 64'd0);
    bus_read(MTIMER_MTIMECMP_LO, d);
    check("rst_cmp", {32'h0, d}, 64'hFFFF_FFFF);
    bus_read(MTIMER_MTIME_LO, d);
    check("rst_mtime", {32'h0, d}, 64'd0);
    check("rst_irq2", {63'h0, irq}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
